// File: rtl/cart_ram_arbiter.sv
// cart_ram_arbiter: shares one 16 KB single-port cartridge RAM between the
// HPS download bus (index 1 only) and CPU reads. Download beats go through a
// one-entry holding register throttled by ioctl_wait. The CPU is held in
// reset while an image loads.
// Build option: define CART_MIRROR_EN to mirror images smaller than 16 KB
// across the CPU address space. Without it, reads past the image return 8'hFF.
module cart_ram_arbiter (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic [13:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rd_data,
  output logic [13:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout,
  output logic        cart_valid,
  output logic [14:0] cart_size,
  output logic        cart_hold,
  output logic        cart_ovf
);

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_DONE, DL_WR, DL_FIN} state_t;

  state_t      state;
  state_t      state_next;

  logic        dl_active;
  logic        dl_prev;
  logic        dl_rise;
  logic        dl_fall;
  logic        fin_pending;
  logic        wr_accept;
  logic        hold_full;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;
  logic        hold_in_range;
  logic [14:0] wr_end;
  logic [13:0] rd_addr;
  logic        rd_blank;

  // Only index 1 counts as a cartridge download; anything else is invisible.
  assign dl_active     = ioctl_download && (ioctl_index == 8'd1);
  assign dl_rise       = dl_active && !dl_prev;
  assign dl_fall       = !dl_active && dl_prev;
  assign wr_accept     = ioctl_wr && dl_active && !hold_full;
  assign ioctl_wait    = hold_full;
  assign hold_in_range = (hold_addr[15:14] == 2'b00);
  // Highest byte count implied by the held beat, clamped at 16 KB.
  assign wr_end        = hold_in_range ? ({1'b0, hold_addr[13:0]} + 15'd1) : 15'd16384;

`ifdef CART_MIRROR_EN
  logic [13:0] mirror_mask;
  logic [13:0] size_m1;
  logic [13:0] smear1;
  logic [13:0] smear2;
  logic [13:0] smear3;
  logic [13:0] mask_next;

  // Smearing the top set bit of size-1 downwards gives the smallest 2^n-1
  // covering the image; a full 16 KB image wraps to 14'h3FFF.
  assign size_m1   = cart_size[13:0] - 14'd1;
  assign smear1    = size_m1 | (size_m1 >> 1);
  assign smear2    = smear1 | (smear1 >> 2);
  assign smear3    = smear2 | (smear2 >> 4);
  assign mask_next = smear3 | (smear3 >> 8);
  assign rd_addr   = cpu_addr & mirror_mask;
  assign rd_blank  = !cart_valid || cart_hold;

  // Mirror mask is recomputed once per load, when the download finishes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mirror_mask <= 14'h3FFF;
    end else if (state == DL_FIN) begin
      mirror_mask <= mask_next;
    end
  end
`else
  assign rd_addr  = cpu_addr;
  assign rd_blank = !cart_valid || cart_hold || ({1'b0, cpu_addr} >= cart_size);
`endif

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration and RAM port drive; writes win over reads, and a write
  // arriving this very cycle already counts as pending.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    case (state)
      IDLE: begin
        if (hold_full || wr_accept) begin
          state_next = DL_WR;
        end else if (cpu_req && !cpu_ack) begin
          state_next = CPU_RD;
        end else if (fin_pending) begin
          state_next = DL_FIN;
        end
      end
      CPU_RD: begin
        ram_addr   = rd_addr;
        state_next = CPU_DONE;
      end
      CPU_DONE: begin
        state_next = IDLE;
      end
      DL_WR: begin
        ram_we   = hold_in_range;
        ram_addr = hold_addr[13:0];
        ram_din  = hold_data;
        // A read that lost arbitration starts straight away, no dead cycle.
        if (cpu_req && !cpu_ack) begin
          state_next = CPU_RD;
        end else begin
          state_next = IDLE;
        end
      end
      DL_FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Holding register, CPU read return and cartridge status bookkeeping.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev     <= 1'b0;
      fin_pending <= 1'b0;
      hold_full   <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rd_data <= 8'hFF;
      cart_valid  <= 1'b0;
      cart_size   <= '0;
      cart_hold   <= 1'b0;
      cart_ovf    <= 1'b0;
    end else begin
      dl_prev <= dl_active;
      cpu_ack <= 1'b0;
      if (state == CPU_DONE) begin
        cpu_ack     <= 1'b1;
        cpu_rd_data <= rd_blank ? 8'hFF : ram_dout;
      end
      if (state == DL_WR) begin
        hold_full <= 1'b0;
        if (!hold_in_range) begin
          cart_ovf <= 1'b1;
        end
        if (wr_end > cart_size) begin
          cart_size <= wr_end;
        end
      end
      if (wr_accept) begin
        hold_full <= 1'b1;
        hold_addr <= ioctl_addr;
        hold_data <= ioctl_data;
      end
      if (state == DL_FIN) begin
        cart_valid  <= (cart_size != 15'd0);
        cart_hold   <= 1'b0;
        fin_pending <= 1'b0;
      end
      if (dl_fall) begin
        fin_pending <= 1'b1;
      end
      // A fresh download always restarts the cartridge, overriding the above.
      if (dl_rise) begin
        cart_valid  <= 1'b0;
        cart_size   <= '0;
        cart_ovf    <= 1'b0;
        cart_hold   <= 1'b1;
        fin_pending <= 1'b0;
      end
    end
  end

endmodule
